wts_ram_arb: RTL and testbench

- Parametrised successor to the single-port wave table RAM.
- One synchronous single-port array shared between two requesters:
  - the CPU register interface: read/write with a req/ack handshake;
  - the sound engine: read-only, one-cycle latency, ready/valid.
- Adds post-reset auto-clear, out-of-range protection, engine-priority arbitration and a starvation guard for the CPU.

---
 rtl/wts_ram_pkg.sv | 17 +
 rtl/wts_ram_core.sv | 28 ++
 rtl/wts_ram_arb.sv | 175 +++++++++++++++++
 tb/tb_wts_ram_arb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wts_ram_pkg.sv
// Shared encodings for the wave table RAM arbiter: FSM states and the
// grant select that says who owns the single array port this cycle.
package wts_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CLR  = 2'd1,
    GNT_ENG  = 2'd2,
    GNT_CPU  = 2'd3
  } gnt_e;

endpackage

// File: rtl/wts_ram_core.sv
// Single-port synchronous wave table array with registered read data.
// Infers one block RAM; contents are not reset (the arbiter clears them).
module wts_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 768
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] q_reg;

  // One access per cycle: optional write, and the word at a is registered out.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[a] <= d;
    end
    q_reg <= mem[a];
  end

  assign q = q_reg;

endmodule

// File: rtl/wts_ram_arb.sv
// Wave table RAM shared by the CPU (req/ack) and the sound engine
// (ready/valid, read-only). After reset every word is cleared, then the
// engine wins each cycle unless a pending CPU request has lost STARVE_LIMIT
// times in a row, in which case the CPU is forced through.
module wts_ram_arb
  import wts_ram_pkg::*;
#(
  parameter int                 DATA_W       = 8,
  parameter int                 ADDR_W       = 10,
  parameter int                 DEPTH        = 768,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE  = '0,
  parameter int                 STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              eng_re,
  input  logic [ADDR_W-1:0] eng_a,
  output logic              eng_ready,
  output logic              eng_valid,
  output logic [DATA_W-1:0] eng_q,
  output logic              busy
);

  localparam int                CNT_W     = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_reg, state_next;
  gnt_e              gnt;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic              cpu_ack_reg;
  logic              cpu_rd_pend_reg;
  logic              eng_valid_reg;
  logic              rd_oor_reg;
  logic [DATA_W-1:0] cpu_q_reg;
  logic [DATA_W-1:0] eng_q_reg;

  logic              core_we;
  logic [ADDR_W-1:0] core_a;
  logic [DATA_W-1:0] core_d;
  logic [DATA_W-1:0] core_q;
  logic [DATA_W-1:0] rd_data;

  logic              cpu_grantable;
  logic              force_cpu;
  logic              cpu_in_range;
  logic              eng_in_range;

  // A request seen while its previous ack is on the bus is never granted.
  assign cpu_grantable = cpu_req && !cpu_ack_reg;
  assign force_cpu     = (state_reg == ST_RUN) && (starve_cnt_reg == LIMIT) && cpu_grantable;
  assign cpu_in_range  = ({1'b0, cpu_a} < DEPTH_EXT);
  assign eng_in_range  = ({1'b0, eng_a} < DEPTH_EXT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: leave the clear right after the last word is written.
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_CLEAR && clr_addr_reg == LAST_ADDR) begin
      state_next = ST_RUN;
    end
  end

  // Arbitration and array port control for the current cycle.
  always_comb begin
    gnt       = GNT_NONE;
    eng_ready = 1'b0;
    core_we   = 1'b0;
    core_a    = clr_addr_reg;
    core_d    = CLEAR_VALUE;
    if (state_reg == ST_CLEAR) begin
      gnt     = GNT_CLR;
      core_we = 1'b1;
    end else begin
      eng_ready = !force_cpu;
      if (force_cpu) begin
        gnt = GNT_CPU;
      end else if (eng_re) begin
        gnt = GNT_ENG;
      end else if (cpu_grantable) begin
        gnt = GNT_CPU;
      end
    end
    case (gnt)
      GNT_ENG: begin
        core_a = eng_in_range ? eng_a : '0;
      end
      GNT_CPU: begin
        core_a  = cpu_in_range ? cpu_a : '0;
        core_d  = cpu_d;
        core_we = cpu_we && cpu_in_range;
      end
      default: ;
    endcase
  end

  // Clear address, starvation counter and one-cycle response flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr_reg    <= '0;
      starve_cnt_reg  <= '0;
      cpu_ack_reg     <= 1'b0;
      cpu_rd_pend_reg <= 1'b0;
      eng_valid_reg   <= 1'b0;
      rd_oor_reg      <= 1'b0;
    end else begin
      if (state_reg == ST_CLEAR) begin
        clr_addr_reg <= clr_addr_reg + 1'b1;
      end
      if (gnt == GNT_CPU) begin
        starve_cnt_reg <= '0;
      end else if (gnt == GNT_ENG && cpu_grantable && starve_cnt_reg != LIMIT) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
      cpu_ack_reg     <= (gnt == GNT_CPU);
      cpu_rd_pend_reg <= (gnt == GNT_CPU) && !cpu_we;
      eng_valid_reg   <= (gnt == GNT_ENG);
      rd_oor_reg      <= ((gnt == GNT_ENG) && !eng_in_range) ||
                         ((gnt == GNT_CPU) && !cpu_in_range);
    end
  end

  // Out-of-range reads return zero instead of whatever the array produced.
  assign rd_data = rd_oor_reg ? '0 : core_q;

  // Hold registers so both read buses keep their last value between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_q_reg <= '0;
      eng_q_reg <= '0;
    end else begin
      if (cpu_rd_pend_reg) begin
        cpu_q_reg <= rd_data;
      end
      if (eng_valid_reg) begin
        eng_q_reg <= rd_data;
      end
    end
  end

  assign cpu_ack   = cpu_ack_reg;
  assign cpu_q     = cpu_rd_pend_reg ? rd_data : cpu_q_reg;
  assign eng_valid = eng_valid_reg;
  assign eng_q     = eng_valid_reg ? rd_data : eng_q_reg;
  assign busy      = (state_reg == ST_CLEAR);

  wts_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk (clk),
    .we  (core_we),
    .a   (core_a),
    .d   (core_d),
    .q   (core_q)
  );

endmodule

// File: tb/tb_wts_ram_arb.sv
// Directed bench for wts_ram_arb with default parameters: reset/clear timing,
// CPU handshake, engine reads, starvation guard, out-of-range access and
// reset during the clear.
module tb_wts_ram_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_a;
  logic [7:0] cpu_d;
  logic       cpu_ack;
  logic [7:0] cpu_q;
  logic       eng_re;
  logic [9:0] eng_a;
  logic       eng_ready;
  logic       eng_valid;
  logic [7:0] eng_q;
  logic       busy;

  int tests = 0;
  int fails = 0;

  wts_ram_arb dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_a     (cpu_a),
    .cpu_d     (cpu_d),
    .cpu_ack   (cpu_ack),
    .cpu_q     (cpu_q),
    .eng_re    (eng_re),
    .eng_a     (eng_a),
    .eng_ready (eng_ready),
    .eng_valid (eng_valid),
    .eng_q     (eng_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles until busy falls; checks no CPU ack and no engine ready meanwhile.
  task automatic wait_clear(input string tag);
    int n = 0;
    bit ack_seen = 0;
    bit rdy_seen = 0;
    while (busy && n < 2000) begin
      #1;
      if (eng_ready) rdy_seen = 1;
      @(negedge clk);
      n++;
      if (cpu_ack) ack_seen = 1;
    end
    chk({tag, " busy cycles"}, n, 768);
    chk({tag, " no ack during clear"}, ack_seen, 0);
    chk({tag, " no eng_ready during clear"}, rdy_seen, 0);
  endtask

  // CPU access starting at a negedge; lat = cycles from request to visible ack.
  task automatic cpu_op(input string tag, input logic we, input logic [9:0] a,
                        input logic [7:0] d, input logic [7:0] exp_q,
                        input int lat, input bit keep);
    int n = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_d = d;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 20);
    $display("[TB] cpu %s we=%0d a=0x%03h d=0x%02h -> ack after %0d q=0x%02h",
             tag, we, a, d, n, cpu_q);
    chk({tag, " ack latency"}, n, lat);
    if (!we) chk({tag, " cpu_q"}, cpu_q, exp_q);
    if (!keep) begin
      cpu_req = 1'b0;
      @(negedge clk);
      chk({tag, " ack one cycle"}, cpu_ack, 0);
    end
  endtask

  // Single engine read starting at a negedge.
  task automatic eng_read(input string tag, input logic [9:0] a, input logic [7:0] exp_q);
    eng_re = 1'b1; eng_a = a;
    #1;
    chk({tag, " eng_ready"}, eng_ready, 1);
    @(negedge clk);
    eng_re = 1'b0;
    $display("[TB] eng %s a=0x%03h -> valid=%0d q=0x%02h", tag, a, eng_valid, eng_q);
    chk({tag, " eng_valid"}, eng_valid, 1);
    chk({tag, " eng_q"}, eng_q, exp_q);
    @(negedge clk);
    chk({tag, " eng_valid drop"}, eng_valid, 0);
    chk({tag, " eng_q hold"}, eng_q, exp_q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
    eng_re = 1'b0; eng_a = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", busy, 1);
    chk("reset cpu_ack", cpu_ack, 0);
    chk("reset cpu_q", cpu_q, 0);
    chk("reset eng_valid", eng_valid, 0);
    chk("reset eng_q", eng_q, 0);
    chk("reset eng_ready", eng_ready, 0);

    // CPU read pending across the whole clear.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 10'h005;
    reset = 1'b0;
    wait_clear("clear1");
    chk("clear1 no ack at busy fall", cpu_ack, 0);
    @(negedge clk);
    $display("[TB] post-clear cpu read a=0x005 -> ack=%0d q=0x%02h", cpu_ack, cpu_q);
    chk("clear1 ack after first grant", cpu_ack, 1);
    chk("clear1 cleared word", cpu_q, 0);
    cpu_req = 1'b0;
    @(negedge clk);

    eng_read("eng 0x000", 10'h000, 8'h00);
    eng_read("eng 0x17f", 10'h17f, 8'h00);
    eng_read("eng 0x2ff", 10'h2ff, 8'h00);

    // Back-to-back write then read.
    cpu_op("wr 0x010", 1'b1, 10'h010, 8'h5A, 8'h00, 1, 1'b1);
    cpu_op("rd 0x010", 1'b0, 10'h010, 8'h00, 8'h5A, 2, 1'b0);
    cpu_op("wr 0x020", 1'b1, 10'h020, 8'h77, 8'h00, 1, 1'b0);

    // Engine streams while a CPU read waits: forced through on the 5th cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 10'h020;
    eng_re = 1'b1; eng_a = 10'h010;
    for (int k = 1; k <= 7; k++) begin
      #1;
      $display("[TB] starve cycle %0d ready=%0d ack=%0d valid=%0d eng_q=0x%02h",
               k, eng_ready, cpu_ack, eng_valid, eng_q);
      chk($sformatf("starve c%0d eng_ready", k), eng_ready, (k == 5) ? 0 : 1);
      chk($sformatf("starve c%0d cpu_ack", k), cpu_ack, (k == 6) ? 1 : 0);
      chk($sformatf("starve c%0d eng_valid", k), eng_valid, (k >= 2 && k != 6) ? 1 : 0);
      if (k >= 2 && k != 6) chk($sformatf("starve c%0d eng_q", k), eng_q, 8'h5A);
      if (k == 6) begin
        chk("starve cpu_q", cpu_q, 8'h77);
        cpu_req = 1'b0;
      end
      @(negedge clk);
    end
    eng_re = 1'b0;
    @(negedge clk);

    // Out-of-range write must not touch the array.
    cpu_op("wr 0x000", 1'b1, 10'h000, 8'h3C, 8'h00, 1, 1'b0);
    cpu_op("wr 0x300 oor", 1'b1, 10'h300, 8'hFF, 8'h00, 1, 1'b0);
    cpu_op("rd 0x300 oor", 1'b0, 10'h300, 8'h00, 8'h00, 1, 1'b0);
    cpu_op("rd 0x000", 1'b0, 10'h000, 8'h00, 8'h3C, 1, 1'b0);
    cpu_op("wr 0x040", 1'b1, 10'h040, 8'h99, 8'h00, 1, 1'b0);
    cpu_op("rd 0x040", 1'b0, 10'h040, 8'h00, 8'h99, 1, 1'b0);
    eng_read("eng 0x040", 10'h040, 8'h99);

    // Reset, then reset again once the clear has reached address 100.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset2 busy", busy, 1);
    chk("reset2 cpu_ack", cpu_ack, 0);
    chk("reset2 eng_valid", eng_valid, 0);
    reset = 1'b0;
    eng_re = 1'b1; eng_a = 10'h040;
    wait_clear("clear2");
    eng_re = 1'b0;
    @(negedge clk);
    cpu_op("rd 0x040 after clear", 1'b0, 10'h040, 8'h00, 8'h00, 1, 1'b0);
    eng_read("eng 0x000 after clear", 10'h000, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
